apb_timer: RTL
==============

APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width matching the bridge's paddr (4KB slave window).
REQ-002 SHALL have parameter PRESC_WIDTH, default 8, width of the prescaler field and counter.
REQ-003 SHALL have port clk, input, 1, single clock for all state.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port psel, input, 1, APB select for this slave.
REQ-006 SHALL have port penable, input, 1, APB access phase.
REQ-007 SHALL have port pwrite, input, 1, APB direction (1 = write).
REQ-008 SHALL have port paddr, input, APB_ADDR_WIDTH, byte address.
REQ-009 SHALL have port pwdata, input, 32, write data.
REQ-010 SHALL have port prdata, output, 32, read data.
REQ-011 SHALL have port pready, output, 1, transfer complete.
REQ-012 SHALL have port pslverr, output, 1, transfer error.
REQ-013 SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 SHALL provide four registers:
- CTRL 0x000 RW: bit0 EN, bit1 RELOAD, bit2 IRQEN, bits[8+PRESC_WIDTH-1:8] PRESC.
- LOAD 0x004 RW.
- COUNT 0x008 RO.
- STATUS 0x00C: bit0 FLAG, write-1-to-clear.
REQ-015 SHALL accept a transfer only when psel&penable, with zero wait states: pready=1 whenever psel&penable.
REQ-016 SHALL drive pslverr=1 in the access phase for any of: paddr[1:0]!=0; paddr above 0x00C; a write to COUNT. Erroring writes SHALL change no state.
REQ-017 SHALL return prdata combinationally from the addressed register; unused bits read 0; prdata=0 when not in a read access phase or on error.
REQ-018 SHALL take effect on register writes at the clk edge ending the access phase.
REQ-019 SHALL run the prescaler (0..PRESC) only while EN=1; tick is asserted in the cycle where the prescaler equals PRESC, and the prescaler then returns to 0. PRESC=0 SHALL tick every cycle.
REQ-020 SHALL update COUNT on each tick:
- COUNT!=0: COUNT-1.
- COUNT==0: set FLAG; reload COUNT from LOAD if RELOAD=1, else clear EN (one-shot) and hold COUNT at 0.
- Period is therefore (LOAD+1)*(PRESC+1) cycles.
REQ-021 SHALL, on a LOAD write, also load COUNT with pwdata and zero the prescaler. This write SHALL override a same-cycle tick, but FLAG set from that tick SHALL still occur.
REQ-022 SHALL zero the prescaler on a CTRL write that changes EN from 0 to 1.
REQ-023 SHALL give FLAG set priority over a same-cycle W1C clear.
REQ-024 SHALL drive irq = FLAG & IRQEN, registered-state only (no combinational path from APB inputs).
REQ-025 SHALL treat 32-bit wrap as impossible: COUNT never decrements below 0.

Reset
REQ-026 SHALL, while rst=1, asynchronously clear CTRL, LOAD, COUNT, FLAG and the prescaler to 0; irq=0.
REQ-027 SHALL abandon any countdown if rst asserts mid-operation; after release the timer stays idle until software sets EN.

Structure
REQ-028 SHALL place register offsets (0x0, 0x4, 0x8, 0xC), CTRL bit positions and the STATUS FLAG position in package apb_timer_pkg.
REQ-029 SHALL implement the prescaler as sub-module apb_timer_prescaler (inputs en, clr, presc; output tick).

Verification
REQ-030 SHALL cover one-shot: LOAD=3, CTRL=0x5 (EN, IRQEN, PRESC=0) -> FLAG and irq rise 4 cycles after the write, EN reads 0, COUNT holds 0.
REQ-031 SHALL cover auto-reload with prescaler: LOAD=2, CTRL=0x103 (PRESC=1) -> FLAG sets every 6 cycles; COUNT sequence 2,1,0,2.
REQ-032 SHALL cover collision: STATUS W1C in the same cycle FLAG sets -> FLAG reads 1 afterwards.
REQ-033 SHALL cover errors: read 0x010, write 0x008, write 0x006 -> pslverr=1, pready=1, registers unchanged, prdata=0.
REQ-034 SHALL cover reset mid-count: assert rst with COUNT=5 -> all registers read 0, irq=0, no tick after release.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg
// Shared register map and field positions for the APB timer.
//   ADDR_*        : byte offsets of the four registers inside the slave window
//   CTRL_*_BIT    : control register bit positions (PRESC occupies
//                   [CTRL_PRESC_LSB +: PRESC_WIDTH])
//   STATUS_FLAG_BIT : position of the sticky expiry flag in STATUS
package apb_timer_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_LOAD   = 4'h4;
  localparam logic [3:0] ADDR_COUNT  = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_RELOAD_BIT = 1;
  localparam int CTRL_IRQEN_BIT  = 2;
  localparam int CTRL_PRESC_LSB  = 8;

  localparam int STATUS_FLAG_BIT = 0;

endpackage

// File: rtl/apb_timer_prescaler.sv
// apb_timer_prescaler
// Counts 0..presc while enabled and flags the last cycle of each period.
//   clk, rst : clock and asynchronous active-high reset
//   en       : count enable (holds the count while low)
//   clr      : synchronous restart of the count at 0 (wins over en)
//   presc    : terminal value; 0 gives a tick every enabled cycle
//   tick     : high in the cycle where the count equals presc
module apb_timer_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [PRESC_WIDTH-1:0] presc,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] cnt_q;

  assign tick = en && (cnt_q == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_timer.sv
// apb_timer
// APB slave timer: prescaled 32-bit down-counter with one-shot or
// auto-reload operation, sticky expiry flag and level interrupt.
//   clk, rst                        : clock, asynchronous active-high reset
//   psel, penable, pwrite, paddr,
//   pwdata                          : APB request (zero wait states)
//   prdata, pready, pslverr         : APB response
//   irq                             : FLAG & IRQEN, from registers only
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int PRESC_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      irq
);

  logic [3:0]             offset;
  logic                   access;
  logic                   addr_err;
  logic                   wr_ok;
  logic                   wr_ctrl;
  logic                   wr_load;
  logic                   wr_status;
  logic                   presc_clr;
  logic                   tick;
  logic                   expire;

  logic                   en_q;
  logic                   reload_q;
  logic                   irqen_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [31:0]            load_q;
  logic [31:0]            count_q;
  logic                   flag_q;
  logic [31:0]            ctrl_rd;

  assign offset = paddr[3:0];
  assign access = psel & penable;

  // Misaligned, beyond STATUS, or a write to read-only COUNT.
  assign addr_err = (offset[1:0] != 2'b00)
                 || (|paddr[APB_ADDR_WIDTH-1:4])
                 || (pwrite && (offset == ADDR_COUNT));

  assign pready  = access;
  assign pslverr = access & addr_err;

  assign wr_ok     = access & pwrite & ~addr_err;
  assign wr_ctrl   = wr_ok && (offset == ADDR_CTRL);
  assign wr_load   = wr_ok && (offset == ADDR_LOAD);
  assign wr_status = wr_ok && (offset == ADDR_STATUS);

  // A tick seen while COUNT is already 0 ends the period.
  assign expire = tick && (count_q == 32'd0);

  // Fresh period on a LOAD write or when the timer is switched on.
  assign presc_clr = wr_load | (wr_ctrl & ~en_q & pwdata[CTRL_EN_BIT]);

  apb_timer_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en_q),
    .clr  (presc_clr),
    .presc(presc_q),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      irqen_q  <= 1'b0;
      presc_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      // Software write to CTRL wins over the one-shot self-disable.
      if (wr_ctrl) begin
        en_q     <= pwdata[CTRL_EN_BIT];
        reload_q <= pwdata[CTRL_RELOAD_BIT];
        irqen_q  <= pwdata[CTRL_IRQEN_BIT];
        presc_q  <= pwdata[CTRL_PRESC_LSB +: PRESC_WIDTH];
      end else if (expire && !reload_q) begin
        en_q <= 1'b0;
      end

      if (wr_load) begin
        load_q <= pwdata;
      end

      // LOAD write overrides the count update of a coincident tick.
      if (wr_load) begin
        count_q <= pwdata;
      end else if (tick) begin
        if (count_q != 32'd0) begin
          count_q <= count_q - 32'd1;
        end else if (reload_q) begin
          count_q <= load_q;
        end
      end

      // Setting has priority over a same-cycle W1C.
      if (expire) begin
        flag_q <= 1'b1;
      end else if (wr_status && pwdata[STATUS_FLAG_BIT]) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign irq = flag_q & irqen_q;

  always_comb begin
    ctrl_rd                                   = '0;
    ctrl_rd[CTRL_EN_BIT]                      = en_q;
    ctrl_rd[CTRL_RELOAD_BIT]                  = reload_q;
    ctrl_rd[CTRL_IRQEN_BIT]                   = irqen_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_WIDTH]    = presc_q;
  end

  always_comb begin
    prdata = '0;
    if (access && !pwrite && !addr_err) begin
      case (offset)
        ADDR_CTRL:   prdata = ctrl_rd;
        ADDR_LOAD:   prdata = load_q;
        ADDR_COUNT:  prdata = count_q;
        ADDR_STATUS: prdata[STATUS_FLAG_BIT] = flag_q;
        default:     prdata = '0;
      endcase
    end
  end

endmodule
